// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - multi-cycle shifter/rotator, STEP bits per clock, start/done handshake
module seq_shifter #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] shift_count,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] shift_out,
  output logic             C,
  output logic             Z
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] opnd;
  logic [CNT_W-1:0] rem;
  logic [2:0]       md;
  logic [WIDTH-1:0] step_val;
  logic             step_c;
  logic             last;
  logic             passthru;

  // A multi-bit step is a chain of single-bit shifts, so carry matches count single shifts.
  always_comb begin
    step_val = opnd;
    step_c   = 1'b0;
    for (int i = 0; i < STEP; i++) begin
      if (i < int'(rem)) begin
        case (md)
          3'd0: begin
            step_c   = step_val[WIDTH-1];
            step_val = {step_val[WIDTH-2:0], 1'b0};
          end
          3'd1: begin
            step_c   = step_val[0];
            step_val = {1'b0, step_val[WIDTH-1:1]};
          end
          3'd2: begin
            step_c   = step_val[WIDTH-1];
            step_val = {step_val[WIDTH-2:0], step_val[WIDTH-1]};
          end
          3'd3: begin
            step_c   = step_val[0];
            step_val = {step_val[0], step_val[WIDTH-1:1]};
          end
          3'd4: begin
            step_c   = step_val[0];
            step_val = {step_val[WIDTH-1], step_val[WIDTH-1:1]};
          end
          default: ;
        endcase
      end
    end
  end

  assign last     = (int'(rem) <= STEP);
  assign passthru = (shift_count == '0) || (mode > 3'd4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      opnd      <= '0;
      rem       <= '0;
      md        <= '0;
      shift_out <= '0;
      C         <= 1'b0;
      Z         <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      ready     <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (passthru) begin
              state     <= DONE;
              shift_out <= data;
              C         <= 1'b0;
              Z         <= (data == '0);
              done      <= 1'b1;
            end else begin
              state <= SHIFT;
              opnd  <= data;
              rem   <= shift_count;
              md    <= mode;
              busy  <= 1'b1;
              ready <= 1'b0;
            end
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          if (last) begin
            state     <= DONE;
            shift_out <= step_val;
            C         <= step_c;
            Z         <= (step_val == '0);
            done      <= 1'b1;
            busy      <= 1'b0;
            ready     <= 1'b1;
          end else begin
            opnd <= step_val;
            rem  <= rem - CNT_W'(STEP);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// tb/tb_seq_shifter.sv - directed bench for seq_shifter, STEP=1 and STEP=4 instances
module tb_seq_shifter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] data;
  logic [2:0] mode;
  logic [2:0] shift_count;
  logic       ready1, busy1, done1, C1, Z1;
  logic       ready4, busy4, done4, C4, Z4;
  logic [7:0] out1, out4;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] r1, r4;
  logic       c1, c4, z1, z4;
  int         lat1, lat4, busy_cnt;

  seq_shifter #(.WIDTH(8), .STEP(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .data(data), .mode(mode),
    .shift_count(shift_count), .ready(ready1), .busy(busy1), .done(done1),
    .shift_out(out1), .C(C1), .Z(Z1)
  );

  seq_shifter #(.WIDTH(8), .STEP(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .data(data), .mode(mode),
    .shift_count(shift_count), .ready(ready4), .busy(busy4), .done(done4),
    .shift_out(out4), .C(C4), .Z(Z4)
  );

  always #5 clk = ~clk;

  // Reference: whole-word shift operators, carry taken from the original operand.
  function automatic logic [8:0] model(input logic [7:0] d, input logic [2:0] m, input int n);
    logic [7:0] r;
    logic       c;
    if (n == 0 || m > 3'd4) begin
      r = d;
      c = 1'b0;
    end else begin
      case (m)
        3'd0:    begin r = d << n; c = d[8-n]; end
        3'd1:    begin r = d >> n; c = d[n-1]; end
        3'd2:    begin r = (d << n) | (d >> (8 - n)); c = r[0]; end
        3'd3:    begin r = (d >> n) | (d << (8 - n)); c = r[7]; end
        default: begin r = 8'($signed(d) >>> n); c = d[n-1]; end
      endcase
    end
    return {c, r};
  endfunction

  function automatic int exp_lat(input logic [2:0] m, input int n, input int step);
    if (n == 0 || m > 3'd4) return 1;
    return (n + step - 1) / step + 1;
  endfunction

  task automatic run_op(input logic [7:0] d, input logic [2:0] m, input logic [2:0] n);
    @(negedge clk);
    data = d; mode = m; shift_count = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat1 = 0; lat4 = 0; busy_cnt = 0;
    for (int cyc = 1; cyc <= 20 && (lat1 == 0 || lat4 == 0); cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (busy1 && lat1 == 0) busy_cnt++;
      if (done1 && lat1 == 0) begin lat1 = cyc; r1 = out1; c1 = C1; z1 = Z1; end
      if (done4 && lat4 == 0) begin lat4 = cyc; r4 = out4; c4 = C4; z4 = Z4; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; data = '0; mode = '0; shift_count = '0;
    repeat (2) @(negedge clk);
    n_chk++; if (out1 !== 8'h00 || C1 !== 1'b0 || Z1 !== 1'b0) begin n_fail++; $display("FAIL reset_out1: got %h C%b Z%b exp 00 C0 Z0", out1, C1, Z1); end
    n_chk++; if (done1 !== 1'b0 || busy1 !== 1'b0 || ready1 !== 1'b1) begin n_fail++; $display("FAIL reset_ctl1: got d%b b%b r%b exp d0 b0 r1", done1, busy1, ready1); end
    n_chk++; if (out4 !== 8'h00 || ready4 !== 1'b1 || busy4 !== 1'b0) begin n_fail++; $display("FAIL reset_dut4: got %h r%b b%b exp 00 r1 b0", out4, ready4, busy4); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_shl_basic();
    run_op(8'b1001_0110, 3'd0, 3'd3);
    n_chk++; if (r1 !== 8'b1011_0000) begin n_fail++; $display("FAIL shl_result: got %h exp b0", r1); end
    n_chk++; if (c1 !== 1'b0 || z1 !== 1'b0) begin n_fail++; $display("FAIL shl_flags: got C%b Z%b exp C0 Z0", c1, z1); end
    n_chk++; if (lat1 !== 4) begin n_fail++; $display("FAIL shl_latency: got %0d exp 4", lat1); end
    n_chk++; if (busy_cnt !== 3) begin n_fail++; $display("FAIL shl_busy_cycles: got %0d exp 3", busy_cnt); end
  endtask

  task automatic test_modes();
    logic [7:0] td[8] = '{8'h81, 8'h81, 8'h80, 8'h01, 8'hA5, 8'h3C, 8'h5A, 8'h00};
    logic [2:0] tm[8] = '{3'd3, 3'd2, 3'd4, 3'd1, 3'd0, 3'd3, 3'd7, 3'd0};
    logic [2:0] tn[8] = '{3'd1, 3'd1, 3'd7, 3'd1, 3'd0, 3'd0, 3'd3, 3'd0};
    logic [7:0] tr[8] = '{8'hC0, 8'h03, 8'hFF, 8'h00, 8'hA5, 8'h3C, 8'h5A, 8'h00};
    logic       tc[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       tz[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    int         tl1[8] = '{2, 2, 8, 2, 1, 1, 1, 1};
    int         tl4[8] = '{2, 2, 3, 2, 1, 1, 1, 1};
    for (int i = 0; i < 8; i++) begin
      run_op(td[i], tm[i], tn[i]);
      n_chk++; if (r1 !== tr[i] || c1 !== tc[i] || z1 !== tz[i] || lat1 !== tl1[i]) begin
        n_fail++; $display("FAIL mode_vec%0d_step1: got %h C%b Z%b lat%0d exp %h C%b Z%b lat%0d", i, r1, c1, z1, lat1, tr[i], tc[i], tz[i], tl1[i]);
      end
      n_chk++; if (r4 !== tr[i] || c4 !== tc[i] || z4 !== tz[i] || lat4 !== tl4[i]) begin
        n_fail++; $display("FAIL mode_vec%0d_step4: got %h C%b Z%b lat%0d exp %h C%b Z%b lat%0d", i, r4, c4, z4, lat4, tr[i], tc[i], tz[i], tl4[i]);
      end
    end
  endtask

  task automatic test_step4();
    logic [7:0] pats[4] = '{8'h96, 8'h81, 8'hA5, 8'h7F};
    logic [8:0] e;
    run_op(8'hFF, 3'd0, 3'd7);
    n_chk++; if (r4 !== 8'h80 || c4 !== 1'b1 || lat4 !== 3) begin n_fail++; $display("FAIL step4_shl_ff: got %h C%b lat%0d exp 80 C1 lat3", r4, c4, lat4); end
    for (int p = 0; p < 4; p++) begin
      for (int m = 0; m < 8; m++) begin
        for (int n = 0; n < 8; n++) begin
          e = model(pats[p], 3'(m), n);
          run_op(pats[p], 3'(m), 3'(n));
          n_chk++; if (r1 !== e[7:0] || c1 !== e[8] || z1 !== (e[7:0] == 8'h00) || lat1 !== exp_lat(3'(m), n, 1)) begin
            n_fail++; $display("FAIL sweep_step1 d=%h m=%0d n=%0d: got %h C%b Z%b lat%0d exp %h C%b lat%0d", pats[p], m, n, r1, c1, z1, lat1, e[7:0], e[8], exp_lat(3'(m), n, 1));
          end
          n_chk++; if (r4 !== e[7:0] || c4 !== e[8] || z4 !== (e[7:0] == 8'h00) || lat4 !== exp_lat(3'(m), n, 4)) begin
            n_fail++; $display("FAIL sweep_step4 d=%h m=%0d n=%0d: got %h C%b Z%b lat%0d exp %h C%b lat%0d", pats[p], m, n, r4, c4, z4, lat4, e[7:0], e[8], exp_lat(3'(m), n, 4));
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    data = 8'h96; mode = 3'd0; shift_count = 3'd3; start = 1'b1;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin data = 8'h81; mode = 3'd2; shift_count = 3'd1; end
      if (cyc == 2) begin
        n_chk++; if (done4 !== 1'b1 || out4 !== 8'hB0) begin n_fail++; $display("FAIL b2b_first_step4: got d%b %h exp d1 b0", done4, out4); end
      end
      if (cyc == 4) begin
        n_chk++; if (done1 !== 1'b1 || out1 !== 8'hB0 || ready1 !== 1'b1) begin n_fail++; $display("FAIL b2b_first_step1: got d%b %h r%b exp d1 b0 r1", done1, out1, ready1); end
        n_chk++; if (done4 !== 1'b1 || out4 !== 8'h03 || C4 !== 1'b1) begin n_fail++; $display("FAIL b2b_second_step4: got d%b %h C%b exp d1 03 C1", done4, out4, C4); end
      end
      if (cyc == 5) begin
        n_chk++; if (done1 !== 1'b0 || busy1 !== 1'b1 || out1 !== 8'hB0) begin n_fail++; $display("FAIL b2b_hold: got d%b b%b %h exp d0 b1 b0", done1, busy1, out1); end
      end
      if (cyc == 6) begin
        n_chk++; if (done1 !== 1'b1 || out1 !== 8'h03 || C1 !== 1'b1) begin n_fail++; $display("FAIL b2b_second_step1: got d%b %h C%b exp d1 03 C1", done1, out1, C1); end
        start = 1'b0;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_busy_ignore();
    int first = 0;
    int ndone = 0;
    logic [7:0] r = '0;
    logic       c = 1'b0;
    @(negedge clk);
    data = 8'h80; mode = 3'd4; shift_count = 3'd7; start = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (done1) begin
        ndone++;
        if (first == 0) begin first = cyc; r = out1; c = C1; end
      end
      if (cyc == 3) begin
        n_chk++; if (done4 !== 1'b1 || out4 !== 8'hFF || C4 !== 1'b0) begin n_fail++; $display("FAIL busy_ign_step4: got d%b %h C%b exp d1 ff C0", done4, out4, C4); end
      end
      start = (cyc == 2 || cyc == 5);
      if (start) begin data = 8'hFF; mode = 3'd0; shift_count = 3'd1; end
    end
    n_chk++; if (first !== 8 || ndone !== 1) begin n_fail++; $display("FAIL busy_ign_timing: got lat%0d pulses%0d exp lat8 pulses1", first, ndone); end
    n_chk++; if (r !== 8'hFF || c !== 1'b0) begin n_fail++; $display("FAIL busy_ign_result: got %h C%b exp ff C0", r, c); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int ndone = 0;
    @(negedge clk);
    data = 8'h80; mode = 3'd4; shift_count = 3'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_chk++; if (out1 !== 8'h00 || C1 !== 1'b0 || Z1 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out: got %h C%b Z%b exp 00 C0 Z0", out1, C1, Z1); end
    n_chk++; if (busy1 !== 1'b0 || ready1 !== 1'b1 || done1 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ctl: got b%b r%b d%b exp b0 r1 d0", busy1, ready1, done1); end
    n_chk++; if (out4 !== 8'h00 || ready4 !== 1'b1) begin n_fail++; $display("FAIL rst_mid_step4: got %h r%b exp 00 r1", out4, ready4); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (done1 || done4) ndone++;
    end
    n_chk++; if (ndone !== 0) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d pulses exp 0", ndone); end
    run_op(8'h96, 3'd1, 3'd2);
    n_chk++; if (r1 !== 8'h25 || c1 !== 1'b1 || z1 !== 1'b0 || lat1 !== 3) begin n_fail++; $display("FAIL rst_mid_after1: got %h C%b Z%b lat%0d exp 25 C1 Z0 lat3", r1, c1, z1, lat1); end
    n_chk++; if (r4 !== 8'h25 || c4 !== 1'b1 || lat4 !== 2) begin n_fail++; $display("FAIL rst_mid_after4: got %h C%b lat%0d exp 25 C1 lat2", r4, c4, lat4); end
  endtask

  initial begin
    test_reset();
    test_shl_basic();
    test_modes();
    test_step4();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
